// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: owner state encoding,
// default starvation limit and the word-alignment helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      OWN_IF = 2'b01,
      OWN_LS = 2'b10
   } owner_e;

   localparam int unsigned STARVE_LIMIT_DEF = 4;

   // Byte address to word-aligned memory address.
   function automatic logic [31:0] word_addr(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and load/store. Load/store normally wins,
// but once it has been granted STARVE_LIMIT times in a row while a fetch
// was waiting, the fetch gets the next slot.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic if_valid_i,
   input  logic ls_valid_i,
   output logic if_gnt_o,
   output logic ls_gnt_o
);

   localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] starve_cnt_q, starve_cnt_d;
   logic          starved;
   logic          ls_wins;

   // Grant selection and next starvation count.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      starved      = (starve_cnt_q == CW'(STARVE_LIMIT));
      ls_wins      = ls_valid_i && !(if_valid_i && starved);
      ls_gnt_o     = !rst && ls_wins;
      if_gnt_o     = !rst && if_valid_i && !ls_wins;
      starve_cnt_d = starve_cnt_q;
      if (!if_valid_i || if_gnt_o) begin
         starve_cnt_d = '0;
      end else if (ls_gnt_o && !starved) begin
         starve_cnt_d = starve_cnt_q + CW'(1);
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it lives inside the clocked branch
      // and is not in the sensitivity list; state uses non-blocking writes.
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between an instruction-fetch
// port and a load/store port. One request is accepted per cycle; its
// response appears on the owner's port the following cycle.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   // fetch port
   input  logic        if_req_valid,
   input  logic [31:0] if_req_addr,
   output logic        if_req_ready,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   output logic        if_rsp_err,
   // load/store port
   input  logic        ls_req_valid,
   input  logic        ls_req_we,
   input  logic [31:0] ls_req_addr,
   input  logic [31:0] ls_req_wdata,
   input  logic [3:0]  ls_req_bmask,
   output logic        ls_req_ready,
   output logic        ls_rsp_valid,
   output logic [31:0] ls_rsp_data,
   // memory
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_bmask,
   input  logic [31:0] mem_rdata
);

   logic   if_gnt, ls_gnt, if_misaligned;
   owner_e owner_q, owner_d;
   logic   err_q, err_d;
   logic   store_q, store_d;

   mem_arb_prio #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio (
      .clk        (clk),
      .rst        (rst),
      .if_valid_i (if_req_valid),
      .ls_valid_i (ls_req_valid),
      .if_gnt_o   (if_gnt),
      .ls_gnt_o   (ls_gnt)
   );

   assign if_req_ready  = if_gnt;
   assign ls_req_ready  = ls_gnt;
   assign if_misaligned = (if_req_addr[1:0] != 2'b00);

   // Memory request mux: winner's request, or all zero when nothing goes out.
   // A misaligned fetch is accepted but never touches the memory.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_bmask = '0;
      if (ls_gnt) begin
         mem_en    = 1'b1;
         mem_we    = ls_req_we;
         mem_addr  = word_addr(ls_req_addr);
         mem_wdata = ls_req_wdata;
         mem_bmask = ls_req_bmask;
      end else if (if_gnt && !if_misaligned) begin
         mem_en    = 1'b1;
         mem_addr  = word_addr(if_req_addr);
         mem_bmask = 4'hF;
      end
   end

   // Owner next state: taken from this cycle's accept, IDLE if none.
   always_comb begin
      owner_d = IDLE;
      err_d   = 1'b0;
      store_d = 1'b0;
      if (ls_gnt) begin
         owner_d = OWN_LS;
         store_d = ls_req_we;
      end else if (if_gnt) begin
         owner_d = OWN_IF;
         err_d   = if_misaligned;
      end
   end

   // Owner register with the response qualifiers of the accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= IDLE;
         err_q   <= 1'b0;
         store_q <= 1'b0;
      end else begin
         owner_q <= owner_d;
         err_q   <= err_d;
         store_q <= store_d;
      end
   end

   // Response routing; gated by rst so an in-flight request never responds.
   always_comb begin
      if_rsp_valid = 1'b0;
      if_rsp_err   = 1'b0;
      if_rsp_data  = '0;
      ls_rsp_valid = 1'b0;
      ls_rsp_data  = '0;
      if (!rst) begin
         case (owner_q)
            OWN_IF: begin
               if_rsp_valid = 1'b1;
               if_rsp_err   = err_q;
               if_rsp_data  = err_q ? '0 : mem_rdata;
            end
            OWN_LS: begin
               ls_rsp_valid = 1'b1;
               ls_rsp_data  = store_q ? '0 : mem_rdata;
            end
            default: ;
         endcase
      end
   end

endmodule
